// File: rtl/lock_pkg.sv
// Shared types and helpers for the digital_lock_core keypad lock.
// Holds the FSM state enum and the button-index width function.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_t;

  // A keypad always needs at least one bit to name a button.
  function automatic int idx_w(input int num_buttons);
    int w;
    w = $clog2(num_buttons);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lock_btn_edge.sv
// Button front end: registers the keypad, detects new presses and encodes
// the pressed button index, flagging cycles where several buttons rose at once.
module lock_btn_edge
  import lock_pkg::*;
#(
  parameter  int NUM_BUTTONS = 4,
  localparam int IDX_W       = idx_w(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic                   press_any,
  output logic                   multi,
  output logic [IDX_W-1:0]       press_idx
);

  logic [NUM_BUTTONS-1:0] btn_q;
  logic [NUM_BUTTONS-1:0] btn_q_prev;
  logic [NUM_BUTTONS-1:0] press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= '0;
      btn_q_prev <= '0;
    end else begin
      btn_q      <= button;
      btn_q_prev <= btn_q;
    end
  end

  assign press     = btn_q & ~btn_q_prev;
  assign press_any = |press;
  // Clearing the lowest set bit leaves something only if two or more rose.
  assign multi     = |(press & (press - NUM_BUTTONS'(1)));

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (press[i]) press_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/digital_lock_core.sv
// Keypad combination lock: code entry with per-digit timeout, relock on press.
// Define LOCK_LOCKOUT_EN to add a timed LOCKOUT state after MAX_TRIES wrong codes.
module digital_lock_core
  import lock_pkg::*;
#(
  parameter  int NUM_BUTTONS    = 4,
  parameter  int CODE_LEN       = 4,
  parameter  int MAX_TRIES      = 3,
  parameter  int LOCKOUT_CYCLES = 1000,
  parameter  int ENTRY_TIMEOUT  = 5000,
  localparam int IDX_W          = idx_w(NUM_BUTTONS),
  localparam int FAIL_W         = $clog2(MAX_TRIES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BUTTONS-1:0]    button,
  input  logic [CODE_LEN*IDX_W-1:0] code,
  output logic                      unlocked,
  output logic                      lockout,
  output logic [CODE_LEN-1:0]       progress,
  output logic [FAIL_W-1:0]         fail_cnt,
  output logic                      err
);

  localparam int CNT_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMR_MAX = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CODE_LEN-1:0] PROG_ONE = CODE_LEN'(1);

  lock_state_t         state, state_d;
  logic [CODE_LEN-1:0] progress_d;
  logic [CNT_W-1:0]    digit_idx, digit_d, cur_idx;
  logic                bad, bad_d, cur_bad, last;
  logic [FAIL_W-1:0]   fail_d;
  logic                err_d;
  logic [TMR_W-1:0]    timer, timer_d;
  logic                press_any, multi;
  logic [IDX_W-1:0]    press_idx, expected_digit;

  lock_btn_edge #(.NUM_BUTTONS(NUM_BUTTONS)) u_btn_edge (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .press_any (press_any),
    .multi     (multi),
    .press_idx (press_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      progress  <= '0;
      digit_idx <= '0;
      bad       <= 1'b0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      timer     <= '0;
      unlocked  <= 1'b0;
    end else begin
      state     <= state_d;
      progress  <= progress_d;
      digit_idx <= digit_d;
      bad       <= bad_d;
      fail_cnt  <= fail_d;
      err       <= err_d;
      timer     <= timer_d;
      unlocked  <= (state_d == ST_UNLOCKED);
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lockout <= 1'b0;
    else     lockout <= (state_d == ST_LOCKOUT);
  end
`else
  assign lockout = 1'b0;
`endif

  // A wrong digit is only remembered in 'bad' so nothing leaks before the last digit.
  always_comb begin
    cur_idx        = (state == ST_IDLE) ? '0 : digit_idx;
    expected_digit = code[int'(cur_idx)*IDX_W +: IDX_W];
    cur_bad        = ((state == ST_ENTRY) && bad) || multi || (press_idx != expected_digit);
    last           = (cur_idx == CNT_W'(CODE_LEN - 1));

    state_d    = state;
    progress_d = progress;
    digit_d    = digit_idx;
    bad_d      = bad;
    fail_d     = fail_cnt;
    err_d      = 1'b0;
    timer_d    = timer;

    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (press_any) begin
          if (last) begin
            digit_d = '0;
            bad_d   = 1'b0;
            if (!cur_bad) begin
              state_d    = ST_UNLOCKED;
              progress_d = '1;
              fail_d     = '0;
            end else begin
              err_d      = 1'b1;
              progress_d = '0;
`ifdef LOCK_LOCKOUT_EN
              fail_d = fail_cnt + FAIL_W'(1);
              if (fail_cnt == FAIL_W'(MAX_TRIES - 1)) begin
                state_d = ST_LOCKOUT;
                timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
              end else begin
                state_d = ST_IDLE;
              end
`else
              state_d = ST_IDLE;
              if (fail_cnt != FAIL_W'(MAX_TRIES)) fail_d = fail_cnt + FAIL_W'(1);
`endif
            end
          end else begin
            state_d    = ST_ENTRY;
            progress_d = (progress << 1) | PROG_ONE;
            digit_d    = cur_idx + CNT_W'(1);
            bad_d      = cur_bad;
            timer_d    = TMR_W'(ENTRY_TIMEOUT - 1);
          end
        end else if (state == ST_ENTRY) begin
          if (timer == '0) begin
            state_d    = ST_IDLE;
            progress_d = '0;
            digit_d    = '0;
            bad_d      = 1'b0;
          end else begin
            timer_d = timer - TMR_W'(1);
          end
        end
      end

      // Progress shows all digits for the unlocking cycle, then clears.
      ST_UNLOCKED: begin
        progress_d = '0;
        if (press_any) state_d = ST_IDLE;
      end

`ifdef LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_digital_lock_core.sv
// Testbench for digital_lock_core: directed steps plus random keypad traffic,
// every cycle compared against a digit-list model of the lock's behaviour.
module tb_digital_lock_core;

  localparam int NB = 4;
  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 20;
  localparam int ET = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button;
  logic [7:0] code;
  logic       unlocked, lockout, err;
  logic [3:0] progress;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 entry, 2 unlocked, 3 lockout.
  int   m_mode;
  int   m_digits[$];
  int   m_fail, m_idle, m_lock;
  bit   m_err, m_full;
  logic [3:0] h1, h2;
  int   code_digits[4] = '{3, 1, 0, 2};

  digital_lock_core #(
    .NUM_BUTTONS(NB), .CODE_LEN(CL), .MAX_TRIES(MT),
    .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .code(code),
    .unlocked(unlocked), .lockout(lockout), .progress(progress),
    .fail_cnt(fail_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_digits.delete(); m_fail = 0; m_idle = 0; m_lock = 0;
    m_err = 0; m_full = 0; h1 = '0; h2 = '0;
  endtask

  task automatic model_edge(input logic [3:0] b);
    logic [3:0] ev;
    int n, d;
    bit ok;
    ev = h1 & ~h2;
    h2 = h1;
    h1 = b;
    n = $countones(ev);
    m_err = 0;
    m_full = 0;
    case (m_mode)
      0, 1: begin
        if (n > 0) begin
          d = (n == 1) ? $clog2(ev) : -1;
          m_digits.push_back(d);
          m_idle = 0;
          m_mode = 1;
          if (m_digits.size() == CL) begin
            ok = 1;
            for (int i = 0; i < CL; i++) if (m_digits[i] != code_digits[i]) ok = 0;
            m_digits.delete();
            if (ok) begin
              m_mode = 2; m_fail = 0; m_full = 1;
            end else begin
              m_err = 1;
`ifdef LOCK_LOCKOUT_EN
              m_fail++;
              if (m_fail == MT) begin m_mode = 3; m_lock = 0; end
              else m_mode = 0;
`else
              if (m_fail < MT) m_fail++;
              m_mode = 0;
`endif
            end
          end
        end else if (m_mode == 1) begin
          m_idle++;
          if (m_idle == ET) begin m_mode = 0; m_digits.delete(); end
        end
      end
      2: if (n > 0) m_mode = 0;
      3: begin
        m_lock++;
        if (m_lock == LC) begin m_mode = 0; m_fail = 0; end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_output(input string tag);
    logic [7:0] ep;
    if (m_mode == 2) ep = m_full ? 8'h0F : 8'h00;
    else             ep = 8'((1 << m_digits.size()) - 1);
    cmp({tag, ".progress"}, {4'h0, progress}, ep);
    cmp({tag, ".unlocked"}, {7'h0, unlocked}, {7'h0, m_mode == 2});
    cmp({tag, ".lockout"},  {7'h0, lockout},  {7'h0, m_mode == 3});
    cmp({tag, ".fail_cnt"}, {6'h0, fail_cnt}, 8'(m_fail));
    cmp({tag, ".err"},      {7'h0, err},      {7'h0, m_err});
  endtask

  task automatic apply_stimulus(input logic [3:0] b, input string tag);
    button = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check_output(tag);
  endtask

  task automatic press(input int d, input string tag);
    apply_stimulus(4'(1 << d), tag);
    apply_stimulus(4'h0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(4'h0, tag);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d, input string tag);
    press(a, tag); press(b, tag); press(c, tag); press(d, tag);
  endtask

  // Reset asserted mid-cycle must clear every output before the next edge.
  task automatic do_reset(input logic [3:0] hold, input string tag);
    #2;
    rst = 1'b1;
    button = hold;
    #1;
    cmp({tag, ".progress"}, {4'h0, progress}, 8'h00);
    cmp({tag, ".unlocked"}, {7'h0, unlocked}, 8'h00);
    cmp({tag, ".lockout"},  {7'h0, lockout},  8'h00);
    cmp({tag, ".fail_cnt"}, {6'h0, fail_cnt}, 8'h00);
    cmp({tag, ".err"},      {7'h0, err},      8'h00);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    button = '0;
    code = 8'h87;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_init");
    rst = 1'b0;

    $display("[TB] correct code then relock");
    enter_code(3, 1, 0, 2, "unlock");
    idle(3, "unlocked_hold");
    press(0, "relock");
    idle(3, "after_relock");

    $display("[TB] wrong code");
    enter_code(3, 1, 0, 1, "wrong1");
    idle(2, "after_wrong1");
    enter_code(0, 0, 0, 0, "wrong2");
    enter_code(2, 2, 2, 2, "wrong3");
    press(3, "lock_ignored");
    press(1, "lock_ignored");
    idle(25, "lockout_wait");

    $display("[TB] entry timeout and multi-press");
    press(3, "timeout");
    press(1, "timeout");
    idle(55, "timeout_idle");
    press(3, "multi");
    apply_stimulus(4'b0111, "multi");
    apply_stimulus(4'b0000, "multi");
    press(0, "multi");
    press(2, "multi");
    idle(2, "after_multi");

    $display("[TB] reset mid-entry and mid-lockout");
    do_reset(4'h0, "reset_entry");
    press(3, "pre_reset");
    press(1, "pre_reset");
    do_reset(4'h0, "reset_mid_entry");
    enter_code(1, 1, 1, 1, "lk1");
    enter_code(1, 1, 1, 1, "lk2");
    enter_code(1, 1, 1, 1, "lk3");
    idle(5, "lk_wait");
    do_reset(4'b1000, "reset_lockout");
    apply_stimulus(4'b1000, "held_after_reset");
    apply_stimulus(4'b1000, "held_after_reset");
    apply_stimulus(4'b0000, "held_after_reset");
    press(1, "held_code");
    press(0, "held_code");
    press(2, "held_code");
    apply_stimulus(4'b0001, "held_relock");
    idle(1, "held_relock");
    apply_stimulus(4'b0001, "held_no_repress");
    apply_stimulus(4'b0001, "held_no_repress");
    idle(3, "held_release");

    $display("[TB] random traffic");
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        for (int j = 0; j < CL; j++) begin
          press(code_digits[j], "rnd_code");
          idle($urandom_range(0, 2), "rnd_gap");
        end
      end else if (r < 8) begin
        for (int j = 0; j < 6; j++) begin
          if ($urandom_range(0, 4) == 0) apply_stimulus(4'($urandom_range(0, 15)), "rnd_vec");
          else apply_stimulus(4'(1 << $urandom_range(0, 3)), "rnd_btn");
          idle($urandom_range(0, 2), "rnd_gap");
        end
      end else if (r == 8) begin
        idle($urandom_range(45, 60), "rnd_long_idle");
      end else begin
        do_reset(4'($urandom_range(0, 15)), "rnd_reset");
      end
    end
    idle(30, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/digital_lock_core.md
DIGITAL_LOCK_CORE -- requirements
Module: digital_lock_core

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4, number of keypad buttons (>=2).
REQ-002 SHALL have parameter CODE_LEN, default 4, digits per code (1..8).
REQ-003 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes before lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000, lockout duration in clk cycles.
REQ-005 SHALL have parameter ENTRY_TIMEOUT, default 5000, idle cycles allowed between digits during entry.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port button  in  NUM_BUTTONS  debounced level inputs, 1 = pressed.
REQ-009 SHALL have port code  in  CODE_LEN*IDX_W  stored code; digit i at [i*IDX_W +: IDX_W], digit 0 entered first; IDX_W = max(1, clog2(NUM_BUTTONS)).
REQ-010 SHALL have port unlocked  out  1  high while in UNLOCKED.
REQ-011 SHALL have port lockout  out  1  high while in LOCKOUT.
REQ-012 SHALL have port progress  out  CODE_LEN  thermometer count of digits entered (drives led).
REQ-013 SHALL have port fail_cnt  out  clog2(MAX_TRIES+1)  consecutive wrong codes.
REQ-014 SHALL have port err  out  1  one-cycle pulse when a completed code is wrong.

Function
REQ-015 SHALL register button once (btn_q); press event = btn_q & ~btn_q_prev per bit; a press is acted on one edge after it appears in btn_q (2-edge latency from input rise to output change).
REQ-016 SHALL implement states IDLE, ENTRY, UNLOCKED, LOCKOUT; all outputs registered.
REQ-017 IDLE: any press records its digit, progress=1, goes to ENTRY (or UNLOCKED directly if CODE_LEN=1 and digit matches).
REQ-018 ENTRY: each press records digit k and shifts progress left-fill; mismatch is flagged internally only, never revealed before digit CODE_LEN.
REQ-019 On press of digit CODE_LEN: all digits match -> UNLOCKED, fail_cnt=0; any mismatch -> err pulse, fail_cnt+1, progress=0, IDLE (or LOCKOUT per REQ-024).
REQ-020 Two or more press events in the same cycle SHALL count as one digit and mark it mismatched.
REQ-021 ENTRY with no press for ENTRY_TIMEOUT cycles SHALL abort to IDLE, progress=0, fail_cnt unchanged, no err.
REQ-022 UNLOCKED: any press SHALL relock -> IDLE, progress=0; that press is not recorded as a digit.
REQ-023 Button held across state changes SHALL generate no further events until released and re-pressed.

Configuration
REQ-024 With LOCK_LOCKOUT_EN defined: wrong code making fail_cnt==MAX_TRIES -> LOCKOUT; presses ignored for LOCKOUT_CYCLES cycles; then fail_cnt=0, IDLE.
REQ-025 Without LOCK_LOCKOUT_EN: no LOCKOUT state, lockout tied 0, fail_cnt saturates at MAX_TRIES, entry always permitted; LOCKOUT_CYCLES unused.

Reset
REQ-026 rst high SHALL immediately force IDLE, unlocked=0, lockout=0, progress=0, fail_cnt=0, err=0, btn_q=0, timers=0, regardless of current state (incl. mid-entry, mid-lockout).
REQ-027 After rst release, a button already held SHALL register as a press on the first edges (btn_q_prev reset to 0).

Structure
REQ-028 Package lock_pkg SHALL hold the state enum, IDX_W function, and state encodings.
REQ-029 Sub-module lock_btn_edge SHALL hold btn_q registers, press-pulse generation, one-hot-to-index encode and multi-press flag.
REQ-030 One shared down-counter SHALL serve ENTRY_TIMEOUT and LOCKOUT_CYCLES.

Verification (NUM_BUTTONS=4, CODE_LEN=4, MAX_TRIES=3, LOCKOUT_CYCLES=20, ENTRY_TIMEOUT=50, code digits 3,1,0,2)
REQ-031 Press 3,1,0,2 -> progress 0001,0011,0111,1111 then unlocked=1, progress=0, fail_cnt=0; press 0 -> unlocked=0.
REQ-032 Press 3,1,0,1 -> err one cycle, fail_cnt=1, unlocked=0, progress=0.
REQ-033 Three wrong codes, LOCK_LOCKOUT_EN defined -> lockout=1 for 20 cycles, presses ignored, then fail_cnt=0; without macro -> fail_cnt stays 3, lockout=0.
REQ-034 Press 3,1 then 50 idle cycles -> progress=0, IDLE, fail_cnt unchanged; buttons 0 and 2 pressed same cycle as digit 1 -> code ends wrong.
REQ-035 Assert rst after 2 digits and during lockout -> all outputs 0 same cycle; 3,1,0,2 then unlocks.
